rtc_bus_arbiter: RTL and testbench

Sequencer and two-way arbiter for the external multiplexed address/data RTC bus (CS, AD, RD, WR, 8-bit bidirectional data). It takes byte-wide read/write requests from two clients: client 0 is the PicoBlaze port-side RTC interface, and client 1 is the irq-driven status/refresh reader. It grants the bus round-robin and produces the full address-latch / strobe / recovery cycle. It sits between the RTC control logic and the top-level tri-state pad, replacing ad-hoc strobe generation.

---
 rtl/rtc_bus_arbiter_if.sv | 33 +++
 rtl/rtc_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_arbiter_if.sv
// Client request/response and RTC pad signals of the bus arbiter.
// The arbiter uses the slave modport; a client/pad model uses the master modport.
interface rtc_bus_arbiter_if;
  logic       req0;
  logic       req1;
  logic       we0;
  logic       we1;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       done0;
  logic       done1;
  logic [7:0] rdata;
  logic       busy;
  logic       CS;
  logic       AD;
  logic       RD;
  logic       WR;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_in,
    output done0, done1, rdata, busy, CS, AD, RD, WR, bus_out, bus_oe
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_in,
    input  done0, done1, rdata, busy, CS, AD, RD, WR, bus_out, bus_oe
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Round-robin two-client sequencer for the multiplexed RTC bus:
// address phase, AD latch, RD/WR strobe and recovery, each T_PHASE cycles.
//
// state     | meaning
// S_IDLE    | strobes high, pad released, arbitrating requests
// S_ADDR    | CS=0 AD=0, captured address driven
// S_LATCH   | AD=1 (RTC latches address), address still driven
// S_STROBE  | WR=0 with write data driven, or RD=0 with pad released
// S_RECOVER | all strobes high, done pulse on the last cycle
module rtc_bus_arbiter #(
  parameter int unsigned T_PHASE = 4
) (
  input logic              clk,
  input logic              reset,
  rtc_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_STROBE,
    S_RECOVER
  } state_t;

  localparam logic [7:0] PH_LOAD = 8'(T_PHASE - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gnt_q, gnt_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;

  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;
  logic       cs_q, cs_d;
  logic       ad_q, ad_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       oe_q, oe_d;
  logic [7:0] out_q, out_d;

  logic       pick1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      ad_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      out_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      ad_q    <= ad_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
    end
  end

  // client 1 wins when alone, or on a tie when client 0 was served last
  assign pick1 = bus.req1 & (~bus.req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          gnt_d   = pick1;
          last_d  = pick1;
          we_d    = pick1 ? bus.we1    : bus.we0;
          addr_d  = pick1 ? bus.addr1  : bus.addr0;
          wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
          cnt_d   = PH_LOAD;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_LATCH, S_STROBE, S_RECOVER: begin
        if (cnt_q == 8'd0) begin
          cnt_d = PH_LOAD;
          case (state_q)
            S_ADDR:   state_d = S_LATCH;
            S_LATCH:  state_d = S_STROBE;
            S_STROBE: begin
              state_d = S_RECOVER;
              if (!we_q) rdata_d = bus.bus_in;
            end
            default:  state_d = S_IDLE;
          endcase
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so every pad pin is a flop
  always_comb begin
    cs_d    = 1'b1;
    ad_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    oe_d    = 1'b0;
    out_d   = 8'd0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_ADDR: begin
        cs_d  = 1'b0;
        ad_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_d;
      end
      S_LATCH: begin
        cs_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_d;
      end
      S_STROBE: begin
        cs_d = 1'b0;
        if (we_d) begin
          wr_d  = 1'b0;
          oe_d  = 1'b1;
          out_d = wdata_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      S_RECOVER: begin
        if (cnt_d == 8'd0) begin
          done0_d = ~gnt_d;
          done1_d = gnt_d;
        end
      end
      default: ;
    endcase
  end

  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.CS      = cs_q;
  assign bus.AD      = ad_q;
  assign bus.RD      = rd_q;
  assign bus.WR      = wr_q;
  assign bus.bus_oe  = oe_q;
  assign bus.bus_out = out_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: T_PHASE=4 and T_PHASE=1 instances, a directed vector
// table, multi-cycle sequences and random traffic against a transaction-level model.
module tb_rtc_bus_arbiter;

  typedef struct packed {
    logic       cs;
    logic       ad;
    logic       rd;
    logic       wr;
    logic       oe;
    logic [7:0] out;
    logic       d0;
    logic       d1;
    logic       busy;
    logic [7:0] rdata;
  } obs_t;

  typedef struct {
    int         t;
    logic       q0;
    logic       q1;
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] b;
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       r0 = 1'b0, r1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
  logic [7:0] a0 = 8'd0, a1 = 8'd0, wd0 = 8'd0, wd1 = 8'd0, bin = 8'd0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  obs_t       obs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_bus_arbiter_if if4();
  rtc_bus_arbiter_if if1();

  rtc_bus_arbiter #(.T_PHASE(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  rtc_bus_arbiter #(.T_PHASE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  assign if4.req0 = r0 & ~sel;
  assign if4.req1 = r1 & ~sel;
  assign if1.req0 = r0 & sel;
  assign if1.req1 = r1 & sel;
  assign if4.we0 = w0;   assign if1.we0 = w0;
  assign if4.we1 = w1;   assign if1.we1 = w1;
  assign if4.addr0 = a0; assign if1.addr0 = a0;
  assign if4.addr1 = a1; assign if1.addr1 = a1;
  assign if4.wdata0 = wd0; assign if1.wdata0 = wd0;
  assign if4.wdata1 = wd1; assign if1.wdata1 = wd1;
  assign if4.bus_in = bin; assign if1.bus_in = bin;

  function automatic obs_t mk(logic c, logic a, logic r, logic w, logic o, logic [7:0] bo,
                              logic x0, logic x1, logic b, logic [7:0] rv);
    obs_t e;
    e.cs = c; e.ad = a; e.rd = r; e.wr = w; e.oe = o; e.out = bo;
    e.d0 = x0; e.d1 = x1; e.busy = b; e.rdata = rv;
    return e;
  endfunction

  function automatic obs_t idle_o(logic [7:0] rv);
    return mk(1, 1, 1, 1, 0, 8'h00, 0, 0, 0, rv);
  endfunction

  always_comb begin
    if (sel) obs = mk(if1.CS, if1.AD, if1.RD, if1.WR, if1.bus_oe, if1.bus_out,
                      if1.done0, if1.done1, if1.busy, if1.rdata);
    else     obs = mk(if4.CS, if4.AD, if4.RD, if4.WR, if4.bus_oe, if4.bus_out,
                      if4.done0, if4.done1, if4.busy, if4.rdata);
  end

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got cs=%b ad=%b rd=%b wr=%b oe=%b out=%h done=%b%b busy=%b rdata=%h, required cs=%b ad=%b rd=%b wr=%b oe=%b out=%h done=%b%b busy=%b rdata=%h",
               name, cyc, got.cs, got.ad, got.rd, got.wr, got.oe, got.out, got.d0, got.d1,
               got.busy, got.rdata, exp.cs, exp.ad, exp.rd, exp.wr, exp.oe, exp.out,
               exp.d0, exp.d1, exp.busy, exp.rdata);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d (0x%0h), required %0d (0x%0h)", name, cyc, got, got, exp, exp);
    end
  endtask

  // Transaction-level model: a granted transaction occupies 4*tp cycles starting
  // the cycle after the grant; its phase is simply the offset divided by tp.
  bit         m_act;
  int         m_start;
  bit         m_g, m_we, m_last;
  logic [7:0] m_addr, m_wdata, m_rdata;

  function automatic obs_t model_exp();
    int   tp, k, ph;
    obs_t e;
    tp = sel ? 1 : 4;
    e  = idle_o(m_rdata);
    if (m_act) begin
      k  = cyc - m_start;
      ph = k / tp;
      e.busy = 1'b1;
      if (ph <= 1) begin
        e.cs = 1'b0; e.ad = (ph == 1); e.oe = 1'b1; e.out = m_addr;
      end else if (ph == 2) begin
        e.cs = 1'b0;
        if (m_we) begin e.wr = 1'b0; e.oe = 1'b1; e.out = m_wdata; end
        else e.rd = 1'b0;
      end
      if (k == 4 * tp - 1) begin e.d0 = !m_g; e.d1 = m_g; end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_last = 1'b1; m_rdata = 8'h00;
  endtask

  task automatic model_step();
    int tp, k;
    tp = sel ? 1 : 4;
    if (m_act) begin
      k = cyc - m_start;
      if (k / tp == 2 && k % tp == tp - 1 && !m_we) m_rdata = bin;
      if (k == 4 * tp - 1) m_act = 1'b0;
    end else if (r0 || r1) begin
      m_g     = (r0 && r1) ? !m_last : r1;
      m_we    = m_g ? w1 : w0;
      m_addr  = m_g ? a1 : a0;
      m_wdata = m_g ? wd1 : wd0;
      m_last  = m_g;
      m_start = cyc + 1;
      m_act   = 1'b1;
    end
  endtask

  // inputs change at the falling edge, so the model steps just after it
  always @(negedge clk) begin
    if (reset) model_reset();
    check("model", obs, model_exp());
    #1;
    if (!reset) model_step();
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #3 reset = 1'b1; r0 = 1'b0; r1 = 1'b0;
    wait_neg(2);
    #3 reset = 1'b0;
    wait_neg(1);
  endtask

  function automatic vec_t row(int t, logic q0, logic q1, logic we, logic [7:0] a,
                               logic [7:0] d, logic [7:0] b, obs_t e);
    vec_t v;
    v.t = t; v.q0 = q0; v.q1 = q1; v.we = we; v.a = a; v.d = d; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic rand_run(input int ncyc);
    for (int i = 0; i < ncyc + 300; i++) begin
      obs_t e;
      bit   gen;
      e   = model_exp();
      gen = (i < ncyc);
      if (r0 && e.d0) begin
        if (!gen || $urandom_range(1) == 0) r0 = 1'b0;
        else begin w0 = 1'($urandom_range(1)); a0 = 8'($urandom); wd0 = 8'($urandom); end
      end else if (!r0 && gen && $urandom_range(3) == 0) begin
        r0 = 1'b1; w0 = 1'($urandom_range(1)); a0 = 8'($urandom); wd0 = 8'($urandom);
      end
      if (r1 && e.d1) begin
        if (!gen || $urandom_range(1) == 0) r1 = 1'b0;
        else begin w1 = 1'($urandom_range(1)); a1 = 8'($urandom); wd1 = 8'($urandom); end
      end else if (!r1 && gen && $urandom_range(3) == 0) begin
        r1 = 1'b1; w1 = 1'($urandom_range(1)); a1 = 8'($urandom); wd1 = 8'($urandom);
      end
      bin = 8'($urandom);
      if (!gen && !r0 && !r1 && !m_act) break;
      @(negedge clk);
    end
    check_int("rand_drain_busy", int'(obs.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   base, budget;
    int   ord[$];
    int   starts[$];
    int   exp_ord[4] = '{0, 1, 0, 1};
    logic pcs;

    vt.push_back(row( 0, 1, 0, 1, 8'h21, 8'h59, 8'h00, idle_o(8'h00)));
    vt.push_back(row( 1, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(0,0,1,1,1,8'h21,0,0,1,8'h00)));
    vt.push_back(row( 4, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(0,0,1,1,1,8'h21,0,0,1,8'h00)));
    vt.push_back(row( 5, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(0,1,1,1,1,8'h21,0,0,1,8'h00)));
    vt.push_back(row( 8, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(0,1,1,1,1,8'h21,0,0,1,8'h00)));
    vt.push_back(row( 9, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(0,1,1,0,1,8'h59,0,0,1,8'h00)));
    vt.push_back(row(12, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(0,1,1,0,1,8'h59,0,0,1,8'h00)));
    vt.push_back(row(13, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(1,1,1,1,0,8'h00,0,0,1,8'h00)));
    vt.push_back(row(15, 1, 0, 1, 8'h21, 8'h59, 8'h00, mk(1,1,1,1,0,8'h00,0,0,1,8'h00)));
    vt.push_back(row(16, 0, 0, 1, 8'h21, 8'h59, 8'h00, mk(1,1,1,1,0,8'h00,1,0,1,8'h00)));
    vt.push_back(row(17, 0, 0, 1, 8'h21, 8'h59, 8'h00, idle_o(8'h00)));
    vt.push_back(row(20, 0, 1, 0, 8'h0C, 8'h00, 8'hA5, idle_o(8'h00)));
    vt.push_back(row(21, 0, 1, 0, 8'h0C, 8'h00, 8'hA5, mk(0,0,1,1,1,8'h0C,0,0,1,8'h00)));
    vt.push_back(row(25, 0, 1, 0, 8'h0C, 8'h00, 8'hA5, mk(0,1,1,1,1,8'h0C,0,0,1,8'h00)));
    vt.push_back(row(29, 0, 1, 0, 8'h0C, 8'h00, 8'hA5, mk(0,1,0,1,0,8'h00,0,0,1,8'h00)));
    vt.push_back(row(32, 0, 1, 0, 8'h0C, 8'h00, 8'hA5, mk(0,1,0,1,0,8'h00,0,0,1,8'h00)));
    vt.push_back(row(33, 0, 1, 0, 8'h0C, 8'h00, 8'hA5, mk(1,1,1,1,0,8'h00,0,0,1,8'hA5)));
    vt.push_back(row(36, 0, 0, 0, 8'h0C, 8'h00, 8'hA5, mk(1,1,1,1,0,8'h00,0,1,1,8'hA5)));
    vt.push_back(row(37, 0, 0, 0, 8'h0C, 8'h00, 8'hA5, idle_o(8'hA5)));
    vt.push_back(row(40, 1, 0, 1, 8'h33, 8'h44, 8'h5A, idle_o(8'hA5)));
    vt.push_back(row(49, 1, 0, 1, 8'h33, 8'h44, 8'h5A, mk(0,1,1,0,1,8'h44,0,0,1,8'hA5)));
    vt.push_back(row(56, 0, 0, 1, 8'h33, 8'h44, 8'h5A, mk(1,1,1,1,0,8'h00,1,0,1,8'hA5)));
    vt.push_back(row(57, 0, 0, 1, 8'h33, 8'h44, 8'h5A, idle_o(8'hA5)));

    wait_neg(1);
    check("reset_state", obs, idle_o(8'h00));
    wait_neg(1);
    #3 reset = 1'b0;
    wait_neg(1);

    // directed vector table, T_PHASE=4
    base = cyc;
    foreach (vt[i]) begin
      while (cyc - base < vt[i].t) @(negedge clk);
      check($sformatf("vec%0d_t%0d", i, vt[i].t), obs, vt[i].exp);
      r0 = vt[i].q0; r1 = vt[i].q1; w0 = vt[i].we; w1 = vt[i].we;
      a0 = vt[i].a; a1 = vt[i].a; wd0 = vt[i].d; wd1 = vt[i].d; bin = vt[i].b;
    end
    wait_neg(2);

    // tie arbitration with both requests held
    do_reset();
    r0 = 1; w0 = 1; a0 = 8'h10; wd0 = 8'h11;
    r1 = 1; w1 = 0; a1 = 8'h20; bin = 8'h77;
    budget = 0;
    while (ord.size() < 4 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (obs.d0) ord.push_back(0);
      if (obs.d1) ord.push_back(1);
      if (ord.size() >= 4) begin r0 = 0; r1 = 0; end
    end
    r0 = 0; r1 = 0;
    check_int("tie_count", ord.size(), 4);
    check_int("tie_cycles", budget, 67);
    for (int i = 0; i < 4; i++)
      check_int($sformatf("tie_order%0d", i), (i < ord.size()) ? ord[i] : -1, exp_ord[i]);
    wait_neg(2);

    // late request during client 0 strobe
    do_reset();
    r0 = 1; w0 = 1; a0 = 8'h3C; wd0 = 8'hC3;
    wait_neg(10);
    r1 = 1; w1 = 0; a1 = 8'h5A; bin = 8'h96;
    wait_neg(6);
    check_int("late_done0", int'(obs.d0), 1);
    r0 = 0;
    wait_neg(1);
    check_int("late_idle_busy", int'(obs.busy), 0);
    wait_neg(1);
    check_int("late_addr1", int'({obs.cs, obs.ad, obs.out}), 32'h05A);
    wait_neg(15);
    check_int("late_done1", int'(obs.d1), 1);
    check_int("late_rdata", int'(obs.rdata), 32'h96);
    r1 = 0;
    wait_neg(2);

    // reset abort during a write strobe
    r0 = 1; w0 = 1; a0 = 8'h21; wd0 = 8'h59;
    wait_neg(10);
    check_int("abort_pre_wr", int'(obs.wr), 0);
    #3 reset = 1'b1; r0 = 0;
    #1 check("abort_async", obs, idle_o(8'h00));
    wait_neg(2);
    #3 reset = 1'b0;
    wait_neg(1);
    r0 = 1;
    wait_neg(1);
    check_int("abort_retry_addr", int'({obs.cs, obs.ad, obs.out}), 32'h021);
    wait_neg(15);
    check_int("abort_retry_done", int'(obs.d0), 1);
    r0 = 0;
    wait_neg(2);

    rand_run(400);

    // T_PHASE=1: back-to-back transactions with alternating direction
    do_reset();
    sel = 1'b1;
    wait_neg(1);
    r0 = 1; w0 = 1; a0 = 8'h01; wd0 = 8'hA0; bin = 8'h3C;
    pcs = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pcs && !obs.cs) starts.push_back(cyc);
      pcs = obs.cs;
      if (obs.d0) begin
        w0 = ~w0; a0 = a0 + 8'd1; wd0 = wd0 + 8'd1; bin = bin + 8'd7;
        if (starts.size() >= 5) r0 = 0;
      end
    end
    r0 = 0;
    check_int("b2b_count", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      check_int($sformatf("b2b_gap%0d", i), starts[i] - starts[i-1], 5);
    wait_neg(2);

    rand_run(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
